// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
// Scan-test sequencer for one chain of CHAIN_LEN scan flops. A run loads a
// pattern into the chain, pulses a single functional capture cycle, then
// unloads the captured response. The response is compared with an expected
// vector under a mask, and the result is reported with a one-cycle DONE.
//
// Ports
//   CK        in   clock shared with the chain flops (rising edge)
//   RST       in   synchronous active-high reset
//   START     in   one-cycle run request (accepted only in IDLE)
//   PAT_IN    in   pattern to load, latched on the accepted START edge
//   EXP_IN    in   expected response, latched on the accepted START edge
//   MASK_IN   in   1 = exclude bit from compare, latched with START
//   SO        in   Q of chain flop CHAIN_LEN-1
//   SE        out  scan enable to all chain flops
//   SI        out  scan data into chain flop 0
//   BUSY      out  high from the cycle after START acceptance until DONE
//   DONE      out  one-cycle pulse; RESP_OUT/MISMATCH valid in that cycle
//   MISMATCH  out  at least one unmasked response bit differs from EXP
//   RESP_OUT  out  captured response, RESP_OUT[i] = value captured in flop i
// -----------------------------------------------------------------------------
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic [CHAIN_LEN-1:0] MASK_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 MISMATCH,
  output logic [CHAIN_LEN-1:0] RESP_OUT
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CAPT   = 3'd2,
    UNLOAD = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  // Pattern shifts left during LOAD; its MSB is SI. Zeros shift in behind
  // it, so SI is naturally 0 once the pattern has been fully emitted.
  logic [CHAIN_LEN-1:0]   pat_q;
  logic [CHAIN_LEN-1:0]   exp_q;
  logic [CHAIN_LEN-1:0]   mask_q;
  // Partial response: only CHAIN_LEN-1 samples need storing, the final
  // sample comes straight from SO on the closing UNLOAD edge.
  logic [CHAIN_LEN-2:0]   resp_q;
  logic                   se_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   mismatch_q;
  logic [CHAIN_LEN-1:0]   resp_out_q;

  logic [CHAIN_LEN-1:0]   resp_d;
  logic [CHAIN_LEN-1:0]   pat_d;
  logic                   mismatch_d;

  // Next-value helpers: response shift (SO sampled before the chain moves),
  // pattern shift, and the masked compare on the completed response.
  always_comb begin
    resp_d     = {resp_q, SO};
    pat_d      = {pat_q[CHAIN_LEN-2:0], 1'b0};
    mismatch_d = |((resp_d ^ exp_q) & ~mask_q);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pat_q      <= '0;
      exp_q      <= '0;
      mask_q     <= '0;
      resp_q     <= '0;
      se_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      resp_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            pat_q   <= PAT_IN;
            exp_q   <= EXP_IN;
            mask_q  <= MASK_IN;
            busy_q  <= 1'b1;
            se_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          pat_q <= pat_d;
          if (cnt_q == LAST_CNT) begin
            se_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= CAPT;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= LOAD;
          end
        end
        CAPT: begin
          se_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= UNLOAD;
        end
        UNLOAD: begin
          resp_q <= resp_d[CHAIN_LEN-2:0];
          if (cnt_q == LAST_CNT) begin
            se_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            resp_out_q <= resp_d;
            mismatch_q <= mismatch_d;
            cnt_q      <= '0;
            state_q    <= FIN;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= UNLOAD;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          se_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pat_q   <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SE       = se_q;
  assign SI       = pat_q[CHAIN_LEN-1];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign MISMATCH = mismatch_q;
  assign RESP_OUT = resp_out_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_chain_ctrl
// Directed bench: a 4-flop and an 8-flop instance, each wired to a behavioural
// scan chain whose capture either holds Q or inverts it.
// -----------------------------------------------------------------------------
module tb_scan_chain_ctrl;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic       RST;
  logic       inv;
  logic       sel;
  int         checks = 0;
  int         errors = 0;

  // 4-flop instance
  logic       start4, so4, se4, si4, busy4, done4, mism4;
  logic [3:0] pat4, exp4, mask4, resp4, chain4;

  // 8-flop instance
  logic       start8, so8, se8, si8, busy8, done8, mism8;
  logic [7:0] pat8, exp8, mask8, resp8, chain8;

  scan_chain_ctrl #(.CHAIN_LEN(4)) dut4 (
    .CK(CK), .RST(RST), .START(start4), .PAT_IN(pat4), .EXP_IN(exp4),
    .MASK_IN(mask4), .SO(so4), .SE(se4), .SI(si4), .BUSY(busy4),
    .DONE(done4), .MISMATCH(mism4), .RESP_OUT(resp4)
  );

  scan_chain_ctrl #(.CHAIN_LEN(8)) dut8 (
    .CK(CK), .RST(RST), .START(start8), .PAT_IN(pat8), .EXP_IN(exp8),
    .MASK_IN(mask8), .SO(so8), .SE(se8), .SI(si8), .BUSY(busy8),
    .DONE(done8), .MISMATCH(mism8), .RESP_OUT(resp8)
  );

  // Chain models: shift SI into flop 0 when SE=1, otherwise capture D.
  always @(posedge CK) begin
    chain4 <= se4 ? {chain4[2:0], si4} : (inv ? ~chain4 : chain4);
    chain8 <= se8 ? {chain8[6:0], si8} : (inv ? ~chain8 : chain8);
  end
  assign so4 = chain4[3];
  assign so8 = chain8[7];

  // Selected-instance views used by the run task
  logic d_done, d_se, d_si, d_busy;
  assign d_done = sel ? done8 : done4;
  assign d_se   = sel ? se8   : se4;
  assign d_si   = sel ? si8   : si4;
  assign d_busy = sel ? busy8 : busy4;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  // Start a run on the selected instance; returns the cycle index of DONE
  // (start edge observed as cycle 1), SE per cycle, the SI load sequence
  // (first bit in MSB) and the number of BUSY cycles. inj>0 pulses a
  // competing START with different data in that cycle.
  task automatic run(input logic [7:0] pat, input logic [7:0] ex,
                     input logic [7:0] mk, input int inj, output int lat,
                     output logic [31:0] se_log, output logic [7:0] si_seq,
                     output int busy_cnt);
    int n;
    n = sel ? 8 : 4;
    pat4 = pat[3:0]; exp4 = ex[3:0]; mask4 = mk[3:0];
    pat8 = pat;      exp8 = ex;      mask8 = mk;
    start4 = ~sel; start8 = sel;
    tick;
    start4 = 1'b0; start8 = 1'b0;
    lat = 1; se_log = '0; si_seq = '0; busy_cnt = 0;
    while (d_done !== 1'b1 && lat < 30) begin
      se_log[lat] = d_se;
      if (lat <= n) si_seq = {si_seq[6:0], d_si};
      if (d_busy) busy_cnt++;
      if (lat == inj) begin
        pat4 = 4'b0110; exp4 = 4'b0000; mask4 = 4'b1111;
        pat8 = 8'h66;   exp8 = 8'h00;   mask8 = 8'hFF;
        start4 = ~sel;  start8 = sel;
      end
      tick;
      start4 = 1'b0; start8 = 1'b0;
      lat++;
    end
    se_log[lat] = d_se;
    if (d_busy) busy_cnt++;
    if (lat >= 30) check_val("done_timeout", 32'(lat), 32'(2 * n + 2));
  endtask

  int          lat, busy_cnt, dn;
  logic [31:0] se_log;
  logic [7:0]  si_seq;

  initial begin
    RST = 1'b1; inv = 1'b0; sel = 1'b0;
    start4 = 1'b0; pat4 = '0; exp4 = '0; mask4 = '0;
    start8 = 1'b0; pat8 = '0; exp8 = '0; mask8 = '0;
    tick; tick;

    // Reset state
    check_val("rst4_outs", 32'({se4, si4, busy4, done4, mism4, resp4}), 32'd0);
    check_val("rst8_outs", 32'({se8, si8, busy8, done8, mism8, resp8}), 32'd0);
    RST = 1'b0;
    tick;

    // Reset in load cycle 2 abandons the run
    pat4 = 4'b1011; exp4 = 4'b1011; mask4 = 4'b0000; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    tick; tick;
    check_val("midload_se", 32'(se4), 32'd1);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    check_val("rstload_se_si_busy", 32'({se4, si4, busy4}), 32'd0);
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      if (done4) dn++;
      tick;
    end
    check_val("rstload_no_done", 32'(dn), 32'd0);

    // Identity capture
    inv = 1'b0;
    run(8'h0B, 8'h0B, 8'h00, 0, lat, se_log, si_seq, busy_cnt);
    check_val("id_lat", 32'(lat), 32'd10);
    check_val("id_si_seq", 32'(si_seq), 32'h0B);
    check_val("id_se_wave", se_log, 32'h3DE);
    check_val("id_busy_cycles", 32'(busy_cnt), 32'd9);
    check_val("id_resp", 32'(resp4), 32'h0B);
    check_val("id_mism", 32'(mism4), 32'd0);
    tick;
    check_val("id_done_pulse", 32'(done4), 32'd0);
    tick;
    check_val("id_resp_hold", 32'(resp4), 32'h0B);

    // Inverting capture, unmasked match
    inv = 1'b1;
    run(8'h0C, 8'h03, 8'h00, 0, lat, se_log, si_seq, busy_cnt);
    check_val("inv_resp", 32'(resp4), 32'h03);
    check_val("inv_mism", 32'(mism4), 32'd0);
    tick;

    // Inverting capture, bit 2 differs
    run(8'h0C, 8'h07, 8'h00, 0, lat, se_log, si_seq, busy_cnt);
    check_val("invx_resp", 32'(resp4), 32'h03);
    check_val("invx_mism", 32'(mism4), 32'd1);
    tick; tick;
    check_val("invx_mism_hold", 32'(mism4), 32'd1);

    // Same difference, masked out
    run(8'h0C, 8'h07, 8'h04, 0, lat, se_log, si_seq, busy_cnt);
    check_val("mask_resp", 32'(resp4), 32'h03);
    check_val("mask_mism", 32'(mism4), 32'd0);
    tick;

    // Competing START during UNLOAD is ignored
    inv = 1'b0;
    run(8'h0B, 8'h0B, 8'h00, 7, lat, se_log, si_seq, busy_cnt);
    check_val("ign_lat", 32'(lat), 32'd10);
    check_val("ign_se_wave", se_log, 32'h3DE);
    check_val("ign_resp", 32'(resp4), 32'h0B);
    check_val("ign_mism", 32'(mism4), 32'd0);
    tick;
    check_val("b2b_idle_done", 32'({done4, busy4}), 32'd0);

    // Back-to-back start in the first idle cycle
    run(8'h04, 8'h04, 8'h00, 0, lat, se_log, si_seq, busy_cnt);
    check_val("b2b_lat", 32'(lat), 32'd10);
    check_val("b2b_resp", 32'(resp4), 32'h04);
    check_val("b2b_mism", 32'(mism4), 32'd0);
    tick;

    // 8-flop waveform and inverting capture
    sel = 1'b1; inv = 1'b1;
    run(8'hA5, 8'h5A, 8'h00, 0, lat, se_log, si_seq, busy_cnt);
    check_val("c8_lat", 32'(lat), 32'd18);
    check_val("c8_se_wave", se_log, 32'h3FDFE);
    check_val("c8_busy_cycles", 32'(busy_cnt), 32'd17);
    check_val("c8_si_seq", 32'(si_seq), 32'hA5);
    check_val("c8_resp", 32'(resp8), 32'h5A);
    check_val("c8_mism", 32'(mism8), 32'd0);
    tick;
    check_val("c8_done_pulse", 32'(done8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Scan-test sequencer that sits directly upstream of a chain of scan flops, driving the chain's SE and SI pins.
- It also sits downstream of the chain's last flop, consuming the final Q as scan-out.
- One operation loads a pattern (shift), pulses one functional capture cycle, then unloads the captured response.
- The unloaded response is compared against an expected vector under a mask, and the result is reported with a DONE pulse.

Parameters:
- CHAIN_LEN, 8, number of scan flops in the chain (≥2).
- CNT_W, $clog2(CHAIN_LEN+1), width of the shift counter (derived; do not override).

Ports:
- CK  input  1  clock; the chain flops share this clock, rising edge.
- RST  input  1  reset; synchronous, active-high.
- START  input  1  one-cycle request to run a load/capture/unload sequence.
- PAT_IN  input  CHAIN_LEN  pattern to load; sampled on the accepted START edge.
- EXP_IN  input  CHAIN_LEN  expected response; sampled on the accepted START edge.
- MASK_IN  input  CHAIN_LEN  1 = exclude bit from compare; sampled on the accepted START edge.
- SO  input  1  Q of chain flop CHAIN_LEN-1.
- SE  output  1  scan enable to all chain flops.
- SI  output  1  scan data into chain flop 0.
- BUSY  output  1  high from the cycle after START acceptance until DONE.
- DONE  output  1  one-cycle pulse; the result is valid in that cycle.
- MISMATCH  output  1  1 = at least one unmasked response bit differs from EXP.
- RESP_OUT  output  CHAIN_LEN  captured response; RESP_OUT[i] is the value captured in flop i.

Behaviour:
- Chain convention: flop i feeds flop i+1 when SE=1; SI enters flop 0; SO is flop CHAIN_LEN-1.
- FSM states: IDLE, LOAD, CAPT, UNLOAD, FIN. All outputs are registered.
- Reset (RST=1 at a CK edge, any state):
  - State goes to IDLE.
  - SE=0, SI=0, BUSY=0, DONE=0, MISMATCH=0, RESP_OUT=0, counter=0.
  - Internal PAT/EXP/MASK registers are cleared.
  - Reset mid-operation abandons the sequence with no DONE; the chain contents are then don't-care.
- IDLE:
  - START=1 latches PAT_IN, EXP_IN and MASK_IN, sets BUSY=1, SE=1, SI=PAT[CHAIN_LEN-1], and moves to LOAD with counter=0.
  - START=0 holds all outputs; RESP_OUT and MISMATCH keep their last values.
- LOAD (exactly CHAIN_LEN cycles with SE=1):
  - In load cycle k (k=0..CHAIN_LEN-1), SI=PAT[CHAIN_LEN-1-k].
  - After the CHAIN_LEN-th edge, flop i holds PAT[i].
  - On the last load cycle's edge, go to CAPT and drive SE=0 and SI=0.
- CAPT: exactly 1 cycle with SE=0, during which the chain captures its functional D. Next state is UNLOAD with SE=1 and SI=0.
- UNLOAD (exactly CHAIN_LEN cycles with SE=1, SI=0):
  - On each edge, sample SO before the chain shifts: resp <= {resp[CHAIN_LEN-2:0], SO}.
  - The first sample is flop CHAIN_LEN-1, so after CHAIN_LEN samples resp[i] = captured flop i.
  - After the last edge, go to FIN with SE=0.
- FIN (1 cycle):
  - DONE=1.
  - RESP_OUT=resp.
  - MISMATCH = |((resp ^ EXP) & ~MASK).
  - BUSY drops to 0 in the same cycle.
  - Next state is IDLE.
- Latency: START accepted at edge t gives SE=1 for cycles t+1..t+CHAIN_LEN, SE=0 at t+CHAIN_LEN+1, SE=1 for t+CHAIN_LEN+2..t+2·CHAIN_LEN+1, and DONE at t+2·CHAIN_LEN+2.
- START while BUSY=1 or in FIN is ignored. It is not queued, and latched PAT/EXP/MASK are unaffected.
- START in the IDLE cycle immediately after FIN is accepted, allowing back-to-back runs with 1 idle cycle.
- X on SO propagates into RESP_OUT. MISMATCH is X only if an unmasked bit is X; a masked X bit never affects MISMATCH.
- The chain's SN/RN are not driven by this block and must be held at 1 during operation.

Test Plan:
- Reset mid-LOAD:
  - Stimulus: CHAIN_LEN=4; START with PAT=4'b1011; assert RST in load cycle 2.
  - Required: next cycle SE=0, SI=0, BUSY=0; no DONE ever; a following START runs normally.
- Shift-through with identity capture:
  - Stimulus: chain model whose functional D = its own Q; PAT=4'b1011, EXP=4'b1011, MASK=0.
  - Required: SI sequence 1,0,1,1; DONE at t+10; RESP_OUT=4'b1011; MISMATCH=0.
- Inverting capture, unmasked:
  - Stimulus: chain D = ~Q; PAT=4'b1100, EXP=4'b0011.
  - Required: RESP_OUT=4'b0011, MISMATCH=0.
  - Then rerun with EXP=4'b0111: MISMATCH=1.
- Masked mismatch:
  - Stimulus: same capture as above, EXP=4'b0111, MASK=4'b0100.
  - Required: MISMATCH=0; RESP_OUT=4'b0011.
- Ignored START and back-to-back:
  - Stimulus: pulse START during UNLOAD with a different PAT.
  - Required: no effect on SE timing or result.
  - Then START in the first IDLE cycle after DONE: accepted; a second DONE arrives exactly 2·CHAIN_LEN+2 cycles later.
- SE waveform check (CHAIN_LEN=8):
  - Required: SE high for 8 cycles, low for 1, high for 8; BUSY high for 17 cycles; DONE is a single-cycle pulse.
